// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS front end.
//   RESET_PC_DEFAULT - default PC loaded on reset
//   NOP_INSTR        - all-zero instruction that fills a pipeline bubble
//   OP_J / OP_BEQ    - opcodes referenced by the decode controller
//   ifid_t           - contents of the IF/ID pipeline register
//   jump_target()    - J-type target address formation
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [5:0]  OP_BEQ           = 6'b000100;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  // Upper nibble comes from the PC+4 of the jump itself, so jumps stay
  // inside the current 256 MB region.
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                              input logic [31:0] instr);
    return {pc_plus4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/flopenrc.sv
// flopenrc: register with asynchronous active-low reset, load enable and
// synchronous clear.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset, loads RESET_VAL
//   en        - load d on the next edge
//   clr       - load zero on the next edge; wins over en
//   d / q     - data in / registered data out (WIDTH bits)
module flopenrc #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch stage with the IF/ID pipeline register.
//   clk, rst_n            - clock, asynchronous active-low reset
//   imem_addr/imem_rdata  - PC to instruction memory / combinational read data
//   stallF, stallD        - hold the PC / hold the IF/ID register
//   flushD                - clear IF/ID to a bubble
//   pcSrcD, pcBranchD     - taken branch and its target, from decode
//   jumpD                 - jump in decode; target formed from instrD
//   instrD, opD, functD   - decode-stage instruction and its op/funct fields
//   pcPlus4D, validD      - PC+4 of instrD, instrD is a real instruction
//   fetchCount            - number of instructions accepted into decode
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcSrcD,
  input  logic [31:0] pcBranchD,
  input  logic        jumpD,
  output logic [31:0] instrD,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic [31:0] pcPlus4D,
  output logic        validD,
  output logic [31:0] fetchCount
);

  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  logic        redirect;
  logic        ifid_clr;
  logic        ifid_load;
  ifid_t       ifid_d;
  ifid_t       ifid_q;
  logic [31:0] fetch_count_d;
  logic [31:0] fetch_count_q;

  // Branch target low bits are forced to word alignment.
  logic [1:0]  unused_branch_lsbs;
  assign unused_branch_lsbs = pcBranchD[1:0];

  assign pc_plus4_f = pc_f + 32'd4;

  // A redirect seen while the PC is stalled is dropped; decode holds the
  // same instruction and re-presents it once the stall lifts.
  assign redirect  = (jumpD | pcSrcD) & ~stallF;
  assign ifid_clr  = flushD | redirect;
  assign ifid_load = ~ifid_clr & ~stallD;

  always_comb begin
    pc_next = pc_plus4_f;
    if (jumpD) begin
      pc_next = jump_target(ifid_q.pc_plus4, ifid_q.instr);
    end else if (pcSrcD) begin
      pc_next = {pcBranchD[31:2], 2'b00};
    end
  end

  flopenrc #(
    .WIDTH     (32),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stallF),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (pc_f)
  );

  always_comb begin
    ifid_d.instr    = imem_rdata;
    ifid_d.pc_plus4 = pc_plus4_f;
    ifid_d.valid    = 1'b1;
  end

  flopenrc #(
    .WIDTH     ($bits(ifid_t)),
    .RESET_VAL ('0)
  ) u_ifid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stallD),
    .clr   (ifid_clr),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (ifid_load) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr  = pc_f;
  assign instrD     = ifid_q.instr;
  assign pcPlus4D   = ifid_q.pc_plus4;
  assign validD     = ifid_q.valid;
  assign opD        = ifid_q.instr[31:26];
  assign functD     = ifid_q.instr[5:0];
  assign fetchCount = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stallF, stallD, flushD, pcSrcD, jumpD;
  logic [31:0] pcBranchD;

  logic [31:0] a0_addr, a0_rdata, a0_instr, a0_pc4, a0_cnt;
  logic [5:0]  a0_op, a0_funct;
  logic        a0_valid;
  logic [31:0] a1_addr, a1_rdata, a1_instr, a1_pc4, a1_cnt;
  logic [5:0]  a1_op, a1_funct;
  logic        a1_valid;

  int unsigned n_checks;
  int unsigned n_fail;
  logic        cmp_en;

  // Instruction memory contents seen by both instances.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem = 32'h2008_0005;
      32'h0000_0004: mem = 32'h8D09_0000;
      32'h0000_0008: mem = 32'hAD09_0004;
      32'h1000_0000: mem = 32'h0800_0010;
      default:       mem = a ^ 32'hA5C3_1234;
    endcase
  endfunction

  assign a0_rdata = mem(a0_addr);
  assign a1_rdata = mem(a1_addr);

  fetch_stage dut0 (
    .clk(clk), .rst_n(rst_n), .imem_addr(a0_addr), .imem_rdata(a0_rdata),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .pcSrcD(pcSrcD),
    .pcBranchD(pcBranchD), .jumpD(jumpD), .instrD(a0_instr), .opD(a0_op),
    .functD(a0_funct), .pcPlus4D(a0_pc4), .validD(a0_valid), .fetchCount(a0_cnt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst_n), .imem_addr(a1_addr), .imem_rdata(a1_rdata),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .pcSrcD(pcSrcD),
    .pcBranchD(pcBranchD), .jumpD(jumpD), .instrD(a1_instr), .opD(a1_op),
    .functD(a1_funct), .pcPlus4D(a1_pc4), .validD(a1_valid), .fetchCount(a1_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model for dut0: architectural state of the fetch stage.
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0; m_cnt <= 32'h0;
    end else begin
      if (!stallF) begin
        if (jumpD)       m_pc <= {m_pc4[31:28], m_instr[25:0], 2'b00};
        else if (pcSrcD) m_pc <= pcBranchD & 32'hFFFF_FFFC;
        else             m_pc <= m_pc + 32'd4;
      end
      if (flushD || ((jumpD || pcSrcD) && !stallF)) begin
        m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      end else if (!stallD) begin
        m_instr <= mem(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
        m_cnt <= m_cnt + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("model imem_addr", a0_addr, m_pc);
      chk("model instrD", a0_instr, m_instr);
      chk("model pcPlus4D", a0_pc4, m_pc4);
      chk("model validD", {31'b0, a0_valid}, {31'b0, m_valid});
      chk("model fetchCount", a0_cnt, m_cnt);
      chk("model opD", {26'b0, a0_op}, {26'b0, m_instr[31:26]});
      chk("model functD", {26'b0, a0_funct}, {26'b0, m_instr[5:0]});
    end
  end

  task automatic drive(input logic sf, input logic sd, input logic fl,
                       input logic ps, input logic jp, input logic [31:0] br);
    stallF = sf; stallD = sd; flushD = fl; pcSrcD = ps; jumpD = jp; pcBranchD = br;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cmp_en = 1'b0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();
    chk("reset imem_addr", a0_addr, 32'h0);
    chk("reset instrD", a0_instr, 32'h0);
    chk("reset validD", {31'b0, a0_valid}, 32'h0);
    chk("reset fetchCount", a0_cnt, 32'h0);
    chk("reset1 imem_addr", a1_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // Sequential fetch.
    tick();
    chk("seq1 addr", a0_addr, 32'h4);
    chk("seq1 instrD", a0_instr, 32'h2008_0005);
    chk("seq1 pc4", a0_pc4, 32'h4);
    chk("wrap pcPlus4D", a1_pc4, 32'h0);
    chk("wrap imem_addr", a1_addr, 32'h0);
    chk("wrap instrD", a1_instr, 32'hFFFF_FFFC ^ 32'hA5C3_1234);
    tick();
    chk("seq2 addr", a0_addr, 32'h8);
    chk("seq2 instrD", a0_instr, 32'h8D09_0000);
    chk("seq2 count", a0_cnt, 32'd2);

    // Full stall at pcF=8.
    drive(1, 1, 0, 0, 0, 32'h0);
    tick(); tick();
    chk("stall addr", a0_addr, 32'h8);
    chk("stall instrD", a0_instr, 32'h8D09_0000);
    chk("stall count", a0_cnt, 32'd2);
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();
    chk("resume addr", a0_addr, 32'hC);
    chk("resume instrD", a0_instr, 32'hAD09_0004);
    chk("resume count", a0_cnt, 32'd3);
    chk("resume valid", {31'b0, a0_valid}, 32'h1);

    // Taken branch with unaligned target.
    drive(0, 0, 0, 1, 0, 32'h0000_0043);
    tick();
    chk("br addr", a0_addr, 32'h40);
    chk("br instrD", a0_instr, 32'h0);
    chk("br valid", {31'b0, a0_valid}, 32'h0);
    chk("br count", a0_cnt, 32'd3);
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();
    chk("br next pc4", a0_pc4, 32'h44);
    chk("br next count", a0_cnt, 32'd4);

    // Jump beats branch.
    drive(0, 0, 0, 1, 0, 32'h1000_0000);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();
    chk("j instrD", a0_instr, 32'h0800_0010);
    chk("j pc4", a0_pc4, 32'h1000_0004);
    drive(0, 0, 0, 1, 1, 32'h0000_0080);
    tick();
    chk("j addr", a0_addr, 32'h1000_0040);
    chk("j count", a0_cnt, 32'd5);

    // Flush beats stallD; PC still advances.
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();
    drive(0, 1, 1, 0, 0, 32'h0);
    tick();
    chk("flush instrD", a0_instr, 32'h0);
    chk("flush valid", {31'b0, a0_valid}, 32'h0);
    chk("flush addr", a0_addr, 32'h1000_0048);
    chk("flush count", a0_cnt, 32'd6);

    // Redirect dropped under stallF.
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();
    drive(1, 1, 0, 1, 0, 32'h0000_0200);
    tick();
    chk("drop addr", a0_addr, 32'h1000_004C);
    chk("drop valid", {31'b0, a0_valid}, 32'h1);
    chk("drop count", a0_cnt, 32'd7);

    // Mixed traffic checked against the model.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom);
      tick();
    end

    // Asynchronous reset mid-cycle while a redirect is pending.
    drive(0, 0, 0, 1, 0, 32'h0000_0300);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst addr", a0_addr, 32'h0);
    chk("arst instrD", a0_instr, 32'h0);
    chk("arst valid", {31'b0, a0_valid}, 32'h0);
    chk("arst count", a0_cnt, 32'h0);
    chk("arst pc4", a0_pc4, 32'h0);
    chk("arst1 addr", a1_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("post arst instrD", a0_instr, 32'h2008_0005);
    chk("post arst addr", a0_addr, 32'h4);
    chk("post arst count", a0_cnt, 32'd1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 imem_addr  output  32  current PC (pcF) to instruction memory.
REQ-005 imem_rdata  input  32  instruction word at imem_addr, combinational read, same cycle.
REQ-006 stallF  input  1  hold PC.
REQ-007 stallD  input  1  hold IF/ID register.
REQ-008 flushD  input  1  clear IF/ID register (hazard-unit request).
REQ-009 pcSrcD  input  1  branch taken, resolved in decode.
REQ-010 pcBranchD  input  32  branch target from decode.
REQ-011 jumpD  input  1  jump decoded in decode; controller output for the instruction currently in instrD.
REQ-012 instrD  output  32  decode-stage instruction.
REQ-013 opD  output  6  instrD[31:26], to controller op.
REQ-014 functD  output  6  instrD[5:0], to controller funct.
REQ-015 pcPlus4D  output  32  PC+4 of the instruction in instrD.
REQ-016 validD  output  1  instrD holds a real fetched instruction (0 = bubble).
REQ-017 fetchCount  output  32  count of instructions accepted into decode.

Function
REQ-018 pcPlus4F = pcF + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-019 jumpTarget = {pcPlus4D[31:28], instrD[25:0], 2'b00}.
REQ-020 Next-PC priority: jumpD > pcSrcD > pcPlus4F; jumpD and pcSrcD both high selects jumpTarget.
REQ-021 pcBranchD[1:0] ignored; PC loaded with {pcBranchD[31:2], 2'b00}.
REQ-022 stallF high: pcF holds and any redirect that cycle is dropped (decode re-presents it while stalled).
REQ-023 redirect = (jumpD | pcSrcD) & ~stallF.
REQ-024 IF/ID clear = flushD | redirect; clear loads instrD=32'h0 (NOP), pcPlus4D=0, validD=0.
REQ-025 Clear has priority over stallD.
REQ-026 No clear, stallD high: instrD, pcPlus4D, validD hold.
REQ-027 No clear, stallD low: instrD<=imem_rdata, pcPlus4D<=pcPlus4F, validD<=1.
REQ-028 Latency: instruction at pcF appears on instrD one edge later when unstalled.
REQ-029 fetchCount increments by 1 on every edge where REQ-027 applies; wraps 0xFFFF_FFFF -> 0; holds otherwise.
REQ-030 opD/functD are combinational slices of instrD (no extra register).

Reset
REQ-031 rst_n low asynchronously forces pcF=RESET_PC, instrD=0, pcPlus4D=0, validD=0, fetchCount=0.
REQ-032 Reset asserted mid-stall or mid-redirect discards the pending redirect; first fetch after release is at RESET_PC.
REQ-033 After rst_n deasserts, the first edge loads imem_rdata at RESET_PC into instrD.

Structure
REQ-034 mips_pkg holds RESET_PC default, NOP_INSTR (32'h0), OP_J (6'b000010), OP_BEQ (6'b000100).
REQ-035 One sub-module flopenrc (async active-low reset, enable, sync clear, parameterised width) used for pcF and IF/ID register.
REQ-036 Next-PC mux and fetchCount logic live in fetch_stage.

Verification
REQ-037 Reset then 3 unstalled cycles, imem returns 0x20080005,0x8D090000,0xAD090004 -> imem_addr 0,4,8; instrD follows one cycle later; fetchCount=3; validD=1.
REQ-038 stallF=stallD=1 for 2 cycles at pcF=0x8 -> imem_addr stays 0x8; instrD and fetchCount unchanged; release resumes at 0x8.
REQ-039 pcSrcD=1, pcBranchD=0x0000_0043 -> next imem_addr 0x40; instrD=0, validD=0 one cycle; fetchCount not incremented.
REQ-040 instrD=0x08000010 (j), pcPlus4D=0x1000_0004, jumpD=1, pcSrcD=1 -> next imem_addr 0x1000_0040.
REQ-041 flushD=1 with stallD=1 -> instrD=0, validD=0; pcF advances if stallF=0.
REQ-042 RESET_PC=0xFFFF_FFFC, one fetch -> pcPlus4D=0x0, imem_addr=0x0; rst_n pulsed low mid-cycle -> outputs reset immediately without clock edge.
